// File: rtl/spi_pkg.sv
// Shared FSM state type and default sizing for the SPI transfer queue.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;
  localparam int unsigned SPI_DEPTH = 8;

  typedef enum logic [1:0] {
    StIdle,
    StWaitBusy,
    StWaitDone
  } xfer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read, occupancy count and full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  localparam logic [AW:0] FullCount = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCount);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  // Refused operations are dropped here so callers can drive raw requests.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/spi_xfer_queue.sv
// Byte queue in front of SPI_Master: TX FIFO, launch FSM and optional RX FIFO.
// RX path is built only when SPI_XFER_QUEUE_RX_EN is defined.
module spi_xfer_queue
  import spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH,
  parameter int unsigned DEPTH = SPI_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  output logic             o_rd_valid,
  output logic [WIDTH-1:0] o_rd_data,
  input  logic             i_rd_ready,
  output logic             o_TX_DV,
  output logic [WIDTH-1:0] o_TX_Byte,
  input  logic             i_TX_Ready,
  input  logic [WIDTH-1:0] i_RX_Byte,
  output logic             o_busy,
  output logic [AW:0]      o_tx_level,
  output logic             o_rx_ovf,
  input  logic             i_clr_ovf
);

  xfer_state_t      state_q, state_d;
  logic             tx_empty, tx_full;
  logic [WIDTH-1:0] tx_head;
  logic             launch, capture;
  logic             tx_dv_q;
  logic [WIDTH-1:0] tx_byte_q;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_tx_fifo (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .push_i (i_wr_valid),
    .wdata_i(i_wr_data),
    .pop_i  (launch),
    .rdata_o(tx_head),
    .full_o (tx_full),
    .empty_o(tx_empty),
    .count_o(o_tx_level)
  );

  assign o_wr_ready = !tx_full;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!tx_empty && i_TX_Ready) begin
          launch  = 1'b1;
          state_d = StWaitBusy;
        end
      end
      // Wait for the master to acknowledge the launch before looking for completion.
      StWaitBusy: begin
        if (!i_TX_Ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (i_TX_Ready) begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= StIdle;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= '0;
    end else begin
      state_q <= state_d;
      tx_dv_q <= launch;
      if (launch) tx_byte_q <= tx_head;
    end
  end

  assign o_TX_DV   = tx_dv_q;
  assign o_TX_Byte = tx_byte_q;
  assign o_busy    = (state_q != StIdle) || !tx_empty;

`ifdef SPI_XFER_QUEUE_RX_EN
  logic        rx_full, rx_empty, rx_ovf_q;
  logic [AW:0] unused_rx_level;

  sync_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_rx_fifo (
    .clk_i  (i_Clk),
    .rst_ni (i_Rst_L),
    .push_i (capture),
    .wdata_i(i_RX_Byte),
    .pop_i  (i_rd_ready),
    .rdata_o(o_rd_data),
    .full_o (rx_full),
    .empty_o(rx_empty),
    .count_o(unused_rx_level)
  );

  assign o_rd_valid = !rx_empty;

  // A new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      rx_ovf_q <= 1'b0;
    end else if (capture && rx_full) begin
      rx_ovf_q <= 1'b1;
    end else if (i_clr_ovf) begin
      rx_ovf_q <= 1'b0;
    end
  end

  assign o_rx_ovf = rx_ovf_q;
`else
  logic unused_rx;

  assign unused_rx  = ^{i_rd_ready, i_clr_ovf, i_RX_Byte, capture};
  assign o_rd_valid = 1'b0;
  assign o_rd_data  = '0;
  assign o_rx_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_queue.sv
// Scoreboard bench for spi_xfer_queue with a behavioural SPI master and queue model.
module tb_spi_xfer_queue;

  localparam int W = 8;
  localparam int D = 8;
`ifdef SPI_XFER_QUEUE_RX_EN
  localparam bit RxEn = 1'b1;
`else
  localparam bit RxEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         wr_valid = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         wr_ready;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         rd_ready = 1'b0;
  logic         tx_dv;
  logic [W-1:0] tx_byte;
  logic         tx_ready = 1'b1;
  logic [W-1:0] rx_byte = '0;
  logic         busy;
  logic [3:0]   tx_level;
  logic         rx_ovf;
  logic         clr_ovf = 1'b0;

  always #5 clk = ~clk;

  spi_xfer_queue #(.WIDTH(W), .DEPTH(D)) dut (
    .i_Clk     (clk),
    .i_Rst_L   (rst_n),
    .i_wr_valid(wr_valid),
    .i_wr_data (wr_data),
    .o_wr_ready(wr_ready),
    .o_rd_valid(rd_valid),
    .o_rd_data (rd_data),
    .i_rd_ready(rd_ready),
    .o_TX_DV   (tx_dv),
    .o_TX_Byte (tx_byte),
    .i_TX_Ready(tx_ready),
    .i_RX_Byte (rx_byte),
    .o_busy    (busy),
    .o_tx_level(tx_level),
    .o_rx_ovf  (rx_ovf),
    .i_clr_ovf (clr_ovf)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: condition not met (t=%0t)", name, $time);
  endtask

  // Reference model: queues of bytes plus a flag for an outstanding transfer.
  byte unsigned tx_q[$];
  byte unsigned exp_tx[$];
  byte unsigned exp_rx[$];
  int           rx_cnt = 0;
  bit           active = 0;
  bit           launched_prev = 0;
  bit           exp_ovf = 0;
  bit           m_busy = 0;
  int           m_cnt = 0;
  byte unsigned m_rx = 0;

  typedef struct packed {
    bit dv;
    int level;
    bit wr_ready;
    bit busy;
    bit rd_valid;
    bit ovf;
  } st_t;
  st_t exp_st[$];
  bit  mon_en = 0;

  // Stimulus knobs read by step().
  bit           k_wr_valid = 0;
  byte unsigned k_wr_data = 0;
  bit           k_rd_ready = 0;
  bit           k_clr = 0;
  bit           k_hold = 0;
  int           k_rx_fixed = -1;
  int           k_busy_min = 1;
  int           k_busy_max = 4;

  // One clock of stimulus plus the model's view of the following rising edge.
  task automatic step(output bit accepted);
    bit cap, launch, pop, ready;
    st_t s;
    @(negedge clk);
    #1;
    cap = 0;
    if (launched_prev) begin
      m_busy = 1;
      m_cnt  = $urandom_range(k_busy_max, k_busy_min);
      m_rx   = (k_rx_fixed >= 0) ? 8'(k_rx_fixed) : 8'($urandom);
      ready  = 0;
    end else if (m_busy) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_busy = 0;
        ready  = 1;
        cap    = 1;
      end else begin
        ready = 0;
      end
    end else begin
      ready = !k_hold;
    end
    tx_ready = ready;
    rx_byte  = cap ? m_rx : 8'($urandom);
    wr_valid = k_wr_valid;
    wr_data  = k_wr_data;
    rd_ready = k_rd_ready;
    clr_ovf  = k_clr;

    launch   = !active && tx_q.size() > 0 && ready && !cap;
    accepted = k_wr_valid && tx_q.size() < D;
    pop      = k_rd_ready && rx_cnt > 0;
    if (launch) begin
      exp_tx.push_back(tx_q.pop_front());
      active = 1;
    end
    if (accepted) tx_q.push_back(k_wr_data);
    launched_prev = launch;
    if (RxEn) begin
      if (cap && rx_cnt == D) exp_ovf = 1;
      else if (k_clr) exp_ovf = 0;
      if (cap && rx_cnt < D) begin
        exp_rx.push_back(m_rx);
        rx_cnt++;
      end
      if (pop) rx_cnt--;
    end
    if (cap) active = 0;

    s.dv       = launch;
    s.level    = tx_q.size();
    s.wr_ready = tx_q.size() < D;
    s.busy     = active || tx_q.size() > 0;
    s.rd_valid = rx_cnt > 0;
    s.ovf      = exp_ovf;
    exp_st.push_back(s);
  endtask

  // Per-cycle status monitor, sampled just after the rising edge.
  initial forever begin
    st_t s;
    @(posedge clk);
    #1;
    if (mon_en && exp_st.size() > 0) begin
      s = exp_st.pop_front();
      chk("tx_dv", tx_dv, s.dv);
      chk("tx_level", tx_level, s.level);
      chk("wr_ready", wr_ready, s.wr_ready);
      chk("busy", busy, s.busy);
      chk("rd_valid", rd_valid, s.rd_valid);
      chk("rx_ovf", rx_ovf, s.ovf);
    end
  end

  // Data monitor: checks each launched byte and each host pop, just before the edge.
  initial forever begin
    @(negedge clk);
    #3;
    if (mon_en && rst_n) begin
      if (tx_dv) begin
        if (exp_tx.size() == 0) fail_now("tx_unexpected_launch");
        else chk("tx_byte", tx_byte, exp_tx.pop_front());
      end
      if (rd_valid && rd_ready) begin
        if (exp_rx.size() == 0) fail_now("rd_unexpected_data");
        else chk("rd_data", rd_data, exp_rx.pop_front());
      end
    end
  end

  task automatic do_reset(input bit check_vals);
    mon_en = 0;
    #2 rst_n = 0;
    #1;
    if (check_vals) begin
      chk("rst_tx_dv", tx_dv, 0);
      chk("rst_tx_byte", tx_byte, 0);
      chk("rst_wr_ready", wr_ready, 1);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_level", tx_level, 0);
      chk("rst_rx_ovf", rx_ovf, 0);
    end
    wr_valid = 0;
    rd_ready = 0;
    clr_ovf  = 0;
    tx_ready = 1;
    rx_byte  = '0;
    tx_q.delete();
    exp_tx.delete();
    exp_rx.delete();
    exp_st.delete();
    rx_cnt = 0;
    active = 0;
    launched_prev = 0;
    m_busy = 0;
    exp_ovf = 0;
    k_wr_valid = 0;
    k_clr = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    mon_en = 1;
  endtask

  task automatic push_byte(input byte unsigned b);
    bit acc = 0;
    int n = 0;
    k_wr_valid = 1;
    k_wr_data  = b;
    while (!acc && n < 200) begin
      step(acc);
      n++;
    end
    k_wr_valid = 0;
    if (!acc) fail_now("push_timeout");
  endtask

  task automatic run_idle(input int max_cyc);
    bit acc;
    int n = 0;
    k_wr_valid = 0;
    while ((active || tx_q.size() > 0) && n < max_cyc) begin
      step(acc);
      n++;
    end
    if (active || tx_q.size() > 0) fail_now("idle_timeout");
    repeat (3) step(acc);
  endtask

  initial begin
    bit acc;
    do_reset(1);

    // Single byte with a fixed echo.
    k_rd_ready = 1;
    k_rx_fixed = 8'h3C;
    push_byte(8'hA5);
    run_idle(50);

    // Burst fill while the master holds ready low.
    k_rx_fixed = -1;
    k_hold = 1;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    k_wr_valid = 1;
    k_wr_data  = 8'h09;
    step(acc);
    chk("burst_level", tx_level, 8);
    chk("burst_full", wr_ready, 0);
    step(acc);
    k_wr_valid = 0;
    repeat (3) step(acc);
    k_hold = 0;
    run_idle(300);

    // RX overflow with the host not draining.
    k_rd_ready = 0;
    for (int i = 0; i < 9; i++) push_byte(8'($urandom));
    run_idle(300);
    chk("ovf_set", rx_ovf, RxEn);
    k_clr = 1;
    step(acc);
    k_clr = 0;
    step(acc);
    chk("ovf_clear", rx_ovf, 0);
    k_rd_ready = 1;
    repeat (12) step(acc);

    // Push on the same edge as a launch pop.
    k_hold = 1;
    for (int i = 0; i < 3; i++) push_byte(8'h40 + 8'(i));
    k_hold = 0;
    k_wr_valid = 1;
    k_wr_data  = 8'h4F;
    step(acc);
    k_wr_valid = 0;
    step(acc);
    chk("simul_level", tx_level, 3);
    run_idle(200);

    // Reset while a transfer waits for completion with four bytes queued.
    k_busy_min = 8;
    k_busy_max = 8;
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    step(acc);
    do_reset(1);
    k_busy_min = 1;
    k_busy_max = 4;
    for (int i = 0; i < 10; i++) begin
      step(acc);
      chk("no_stale_dv", tx_dv, 0);
    end

    // Randomised traffic in segments with different drain rates.
    for (int seg = 0; seg < 5; seg++) begin
      for (int i = 0; i < 300; i++) begin
        k_wr_valid = ($urandom % 2) == 0;
        k_wr_data  = 8'($urandom);
        k_rd_ready = ($urandom % 4) < seg;
        k_clr      = ($urandom % 32) == 0;
        k_hold     = ($urandom % 8) == 0;
        step(acc);
      end
    end

    k_hold = 0;
    k_clr = 0;
    run_idle(500);
    k_rd_ready = 1;
    repeat (20) step(acc);
    chk("tx_all_sent", exp_tx.size(), 0);
    chk("rx_all_read", exp_rx.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_xfer_queue.md
# spi_xfer_queue

Byte-stream front end for `SPI_Master`, sitting directly upstream of it.
- Accepts TX bytes from a host over a valid/ready interface and buffers them in a FIFO.
- Launches one SPI transfer per byte with a single-cycle `i_TX_DV` pulse, gated on the master's ready flag.
- Captures each returned `o_RX_Byte` into an RX FIFO, which the host drains through a second valid/ready interface.

## Interface
Parameters:
- `WIDTH`, 8: byte width; must match `SPI_Master` `WIDTH`.
- `DEPTH`, 8: entries per FIFO; power of two, ≥2. `AW = $clog2(DEPTH)`.

Ports:
- `i_Clk` in 1: system clock, same clock as `SPI_Master`.
- `i_Rst_L` in 1: asynchronous, active-low reset.
- `i_wr_valid` in 1: host TX byte valid.
- `i_wr_data` in WIDTH: host TX byte.
- `o_wr_ready` out 1: TX FIFO not full.
- `o_rd_valid` out 1: RX FIFO not empty.
- `o_rd_data` out WIDTH: RX FIFO head. Show-ahead: valid whenever `o_rd_valid` is high.
- `i_rd_ready` in 1: host pops the RX head.
- `o_TX_DV` out 1: launch pulse to the master.
- `o_TX_Byte` out WIDTH: byte to the master, registered.
- `i_TX_Ready` in 1: master idle.
- `i_RX_Byte` in WIDTH: master received byte.
- `o_busy` out 1: state ≠ IDLE, or TX FIFO not empty.
- `o_tx_level` out AW+1: TX FIFO occupancy, 0..DEPTH.
- `o_rx_ovf` out 1: sticky RX overflow flag.
- `i_clr_ovf` in 1: clears `o_rx_ovf`.

## Operation
- **Host push:** occurs when `i_wr_valid && o_wr_ready`. A write while full is ignored; the host must hold the byte.
- **Host pop:** occurs when `o_rd_valid && i_rd_ready`.
- **FSM states:** IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if TX FIFO not empty and `i_TX_Ready`, then pop the TX head into `o_TX_Byte`, set `o_TX_DV=1`, and go to WAIT_BUSY.
  - WAIT_BUSY: `o_TX_DV` returns to 0. Stay until `i_TX_Ready==0`, then go to WAIT_DONE.
  - WAIT_DONE: when `i_TX_Ready==1`, capture `i_RX_Byte` into the RX FIFO and go to IDLE.
- **RX FIFO full at capture:** the byte is dropped and `o_rx_ovf` is set. The FSM still returns to IDLE; TX is never stalled by RX.
- **RX FIFO push and pop in the same cycle:** both take effect.
- **`o_rx_ovf`:** `i_clr_ovf` clears it. If clear and a new overflow occur in the same cycle, the overflow wins.
- **TX FIFO push and pop in the same cycle:** both take effect and the level is unchanged. When full, the push is still refused because `o_wr_ready` is low.
- **Pointers:** AW bits, wrapping modulo DEPTH. Full/empty are derived from an (AW+1)-bit count.

## Timing
- **Reset values:** `o_TX_DV=0`, `o_TX_Byte=0`, `o_wr_ready=1`, `o_rd_valid=0`, `o_rd_data=0` (don't-care while `o_rd_valid` is low), `o_busy=0`, `o_tx_level=0`, `o_rx_ovf=0`. State is IDLE and both FIFOs are empty.
- **Reset mid-transfer:** the queued bytes and the in-flight capture are discarded. The master is reset by the same `i_Rst_L`.
- **Push to launch:** a byte pushed at edge N, with the FIFO empty and `i_TX_Ready` high, drives `o_TX_DV` high after edge N+1, for exactly one cycle.
- **`o_tx_level`:** reflects a push or pop one cycle after the edge on which it occurred.
- **RX capture to host:** `o_rd_valid` rises the cycle after the capture edge.
- **Launch rate:** at most one launch per completed transfer. Back-to-back launches require `i_TX_Ready` to fall and rise between them.

## Configuration
- Macro `SPI_XFER_QUEUE_RX_EN`.
  - **Defined:** RX FIFO and overflow logic are present, as described above.
  - **Undefined:**
    - No RX FIFO is built and the received byte is discarded.
    - `o_rd_valid` and `o_rx_ovf` are tied to 0; `o_rd_data` is tied to 0.
    - `i_rd_ready`, `i_clr_ovf` and `i_RX_Byte` are unused.
    - The FSM behaves identically.

## Structure
- **Package `spi_pkg`:** FSM state enum `xfer_state_t` (IDLE, WAIT_BUSY, WAIT_DONE) and default `SPI_WIDTH=8` / `SPI_DEPTH=8` constants.
- **Sub-module `sync_fifo`** (WIDTH, DEPTH): count, show-ahead read, full/empty. It is instantiated twice, or once when the macro is undefined.

## Test plan
- **Reset then single byte:** push 0xA5 with a master model echoing 0x3C → one `o_TX_DV` pulse with `o_TX_Byte=0xA5`; then `o_rd_valid` with `o_rd_data=0x3C`, and `o_busy` returns to 0.
- **Burst fill:** push 8 bytes 0x01..0x08 while `i_TX_Ready` is held low → `o_tx_level=8` and `o_wr_ready=0`; a ninth push is ignored. After release, the bytes are sent in order 0x01..0x08 with 8 `o_TX_DV` pulses.
- **RX overflow:** 9 transfers with `i_rd_ready=0` → 8 bytes retained, the 9th dropped, `o_rx_ovf=1`; `i_clr_ovf` pulse → `o_rx_ovf=0`.
- **Simultaneous push/pop:** with the TX FIFO at level 3, push on the same cycle as a launch pop → level stays 3 and order is preserved.
- **Async reset mid-transfer:** assert `i_Rst_L=0` in WAIT_DONE with 4 bytes queued → all outputs take their reset values immediately; after reset, no stale `o_TX_DV`.
- **Macro undefined:** repeat the single-byte test → TX is identical, while `o_rd_valid` and `o_rx_ovf` stay 0.
